// File: rtl/ones_window_stats.sv
// ones_window_stats: windowed sum/max/min/threshold statistics over WINDOW accepted ones counts.
module ones_window_stats #(
  parameter int CNT_W  = 3,
  parameter int WINDOW = 8,
  parameter int SUM_W  = 6,
  parameter int THRESH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_max,
  output logic [CNT_W-1:0] out_min,
  output logic             out_over
);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [SUM_W-1:0] sum, new_sum;
  logic [CNT_W-1:0] run_max, run_min, new_max, new_min;
  logic acc, last;
  if (WINDOW < 2) begin : g_bad_window
    $error("ones_window_stats: WINDOW must be at least 2");
  end
  always_comb begin
    in_ready  = state == ACCUM;
    out_valid = state == HOLD;
    acc       = in_valid & in_ready & ~clear;
    last      = acc && cnt == CW'(WINDOW - 1);
    new_sum   = sum + SUM_W'(in_count);
    new_max   = in_count > run_max ? in_count : run_max;
    new_min   = in_count < run_min ? in_count : run_min;
    state_n   = clear ? ACCUM : last ? HOLD : (out_valid && out_ready) ? ACCUM : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ACCUM;
      cnt      <= '0;
      sum      <= '0;
      run_max  <= '0;
      run_min  <= '1;
      out_sum  <= '0;
      out_max  <= '0;
      out_min  <= '0;
      out_over <= 1'b0;
    end else begin
      state <= state_n;
      if (clear || last) begin
        cnt     <= '0;
        sum     <= '0;
        run_max <= '0;
        run_min <= '1;
      end else if (acc) begin
        cnt     <= cnt + CW'(1);
        sum     <= new_sum;
        run_max <= new_max;
        run_min <= new_min;
      end
      // result includes the sample accepted on this same edge
      if (last) begin
        out_sum  <= new_sum;
        out_max  <= new_max;
        out_min  <= new_min;
        out_over <= 32'(new_sum) >= THRESH;
      end
    end
  end
endmodule

// File: doc/ones_window_stats.md
Name: ones_window_stats

Overview:
- Downstream consumer of the 7-bit ones-counter stage.
- Takes the per-sample 3-bit ones count through a valid/ready handshake and accumulates statistics over a fixed window of WINDOW accepted samples: sum, maximum, minimum and a threshold flag.
- Presents one registered result per window on a valid/ready output handshake to the next stage (reporting/control logic).

Parameters:
- CNT_W, 3: width of the incoming ones count.
- WINDOW, 8: number of accepted samples per window; integer 2..64.
- SUM_W, 6: sum width; must satisfy 2^SUM_W - 1 >= (2^CNT_W - 1) * WINDOW.
- THRESH, 20: out_over asserts when the window sum is >= THRESH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- clear  in  1  synchronous abandon/restart of the current window.
- in_valid  in  1  in_count is valid this cycle.
- in_count  in  CNT_W  ones count from the upstream counter stage.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  SUM_W  sum of the WINDOW counts.
- out_max  out  CNT_W  largest count in the window.
- out_min  out  CNT_W  smallest count in the window.
- out_over  out  1  out_sum >= THRESH.

Behaviour:
- Reset (rst=0, async): state=ACCUM, sample counter=0, sum=0, run_max=0, run_min=all-ones. Outputs: in_ready=1, out_valid=0, out_sum=0, out_max=0, out_min=0, out_over=0.
- FSM has two states, ACCUM and HOLD.
- ACCUM: in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready at the rising edge.
  - On accept: sum += in_count, run_max = max(run_max, in_count), run_min = min(run_min, in_count), counter += 1.
  - Cycles with in_valid=0 change nothing. Gaps are allowed anywhere in a window.
- Window complete (accept while counter == WINDOW-1):
  - The final result includes that last sample and is registered into out_sum/out_max/out_min/out_over.
  - Running accumulators and the counter return to their reset values.
  - FSM moves to HOLD.
  - Latency: out_valid=1 in the cycle immediately after the edge that accepted the last sample.
- HOLD: out_valid=1, in_ready=0.
  - in_valid is ignored and no sample is consumed.
  - Output fields are held stable until the handshake completes.
  - On out_valid & out_ready at an edge: out_valid=0, in_ready=1 next cycle, FSM returns to ACCUM.
  - This gives a fixed one-cycle bubble. Output fields keep their last value after the handshake; they are only meaningful while out_valid=1.
- Arithmetic: unsigned. The sum cannot overflow given the SUM_W constraint. out_over is computed from the final sum (including the last sample) and registered with the other fields.
- clear=1 at an edge, in either state:
  - Accumulators and counter go to reset values and FSM goes to ACCUM, so out_valid=0 and in_ready=1 next cycle.
  - A pending result is discarded.
  - A sample offered in the same cycle is not accepted.
  - clear has priority over every other event.
- Async reset mid-window or mid-HOLD: all state goes to reset values immediately; a partial window or pending result is lost.
- Equal values: max/min comparisons are non-strict; a window of identical counts gives out_max = out_min = that count.
- WINDOW=1 is illegal; a simulation assertion flags it.

Test Plan:
- Reset, then 8 back-to-back accepted counts 1,3,5,5,3,0,0,7 with out_ready=1 -> one cycle after the 8th accept: out_valid=1, out_sum=24, out_max=7, out_min=0, out_over=1. in_ready=0 for that one cycle, then 1.
- Eight counts of 2 with in_valid gaps of 0-3 cycles between samples -> out_sum=16, out_max=2, out_min=2, out_over=0. The result appears only after the 8th accepted sample.
- Complete a window with out_ready=0 for 5 cycles while in_valid=1 with count 7 -> out fields stable, out_valid=1, in_ready=0, no sample consumed. Raise out_ready -> handshake; the next window starts fresh with sum 0.
- Eight counts of 7 -> out_sum=56 (max representable product), out_max=7, out_min=7, out_over=1, no wrap.
- Accept 4 samples, pulse clear together with in_valid=1 and count 5 -> that sample is dropped. Then 8 counts of 1 -> out_sum=8, not 8+partial.
- Assert rst=0 asynchronously mid-HOLD (between clock edges) -> out_valid=0 and in_ready=1 immediately. After release, a full window produces the correct fresh result.
